// File: rtl/vga_timing_gen_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// vga_timing_gen_if : raster coordinate/sync bundle from the timing generator
// Revision          : 1.0
//------------------------------------------------------------------------------
interface vga_timing_gen_if;
  logic [9:0]  sx;
  logic [9:0]  sy;
  logic        active_pixel;
  logic        hsync;
  logic        vsync;
  logic        line_start;
  logic        frame_start;
  logic [15:0] frame_count;

  modport master (
    output sx, sy, active_pixel, hsync, vsync, line_start, frame_start, frame_count
  );

  modport slave (
    input sx, sy, active_pixel, hsync, vsync, line_start, frame_start, frame_count
  );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
//------------------------------------------------------------------------------
// vga_timing_gen : 640x480@60 raster timing with registered, coordinate-aligned
//                  qualifiers and syncs
// Revision       : 1.0
//------------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int HA     = 640,
  parameter int HFP    = 16,
  parameter int HSW    = 96,
  parameter int HBP    = 48,
  parameter int VA     = 480,
  parameter int VFP    = 10,
  parameter int VSW    = 2,
  parameter int VBP    = 33,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0
) (
  input  logic                    clk_25,
  input  logic                    rst,
  vga_timing_gen_if.master        vga_o
);

  localparam int c_HTOTAL = HA + HFP + HSW + HBP;
  localparam int c_VTOTAL = VA + VFP + VSW + VBP;

  localparam logic [9:0] c_HMAX     = 10'(c_HTOTAL - 1);
  localparam logic [9:0] c_VMAX     = 10'(c_VTOTAL - 1);
  localparam logic [9:0] c_HA       = 10'(HA);
  localparam logic [9:0] c_VA       = 10'(VA);
  localparam logic [9:0] c_HS_START = 10'(HA + HFP);
  localparam logic [9:0] c_HS_END   = 10'(HA + HFP + HSW);
  localparam logic [9:0] c_VS_START = 10'(VA + VFP);
  localparam logic [9:0] c_VS_END   = 10'(VA + VFP + VSW);

  generate
    if ((c_HTOTAL - 1 > 1023) || (c_VTOTAL - 1 > 1023)) begin : g_width_check
      $error("vga_timing_gen: HTOTAL-1 and VTOTAL-1 must fit in 10 bits");
    end
  endgenerate

  logic [9:0]  sx_q, sx_d;
  logic [9:0]  sy_q, sy_d;
  logic        active_q, active_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;
  logic [15:0] frame_count_q, frame_count_d;

  // Decode from the next-state coordinates so every flop lands aligned with sx/sy.
  always_comb begin
    sx_d = sx_q + 10'd1;
    sy_d = sy_q;
    if (sx_q == c_HMAX) begin
      sx_d = '0;
      sy_d = (sy_q == c_VMAX) ? '0 : sy_q + 10'd1;
    end
    active_d      = (sx_d < c_HA) && (sy_d < c_VA);
    hsync_d       = ((sx_d >= c_HS_START) && (sx_d < c_HS_END)) ? HS_POL : ~HS_POL;
    vsync_d       = ((sy_d >= c_VS_START) && (sy_d < c_VS_END)) ? VS_POL : ~VS_POL;
    line_start_d  = (sx_d == '0);
    frame_start_d = line_start_d && (sy_d == '0);
    frame_count_d = frame_start_d ? frame_count_q + 16'd1 : frame_count_q;
  end

  // Reset parks the raster on the last pixel so the first free edge starts frame 1.
  always_ff @(posedge clk_25) begin
    if (rst) begin
      sx_q          <= c_HMAX;
      sy_q          <= c_VMAX;
      active_q      <= 1'b0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      sx_q          <= sx_d;
      sy_q          <= sy_d;
      active_q      <= active_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign vga_o.sx           = sx_q;
  assign vga_o.sy           = sy_q;
  assign vga_o.active_pixel = active_q;
  assign vga_o.hsync        = hsync_q;
  assign vga_o.vsync        = vsync_q;
  assign vga_o.line_start   = line_start_q;
  assign vga_o.frame_start  = frame_start_q;
  assign vga_o.frame_count  = frame_count_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// tb_vga_timing_gen : full-size, inverted-polarity and small-geometry instances
//                     checked against a raster-position model plus literals
// Revision          : 1.0
//------------------------------------------------------------------------------
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0]  sx;
    logic [9:0]  sy;
    logic        act;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
    logic [15:0] fc;
  } exp_t;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  bit          m_valid;
  bit          m_rst;
  longint      k;
  logic [15:0] base_s;

  vga_timing_gen_if vif ();
  vga_timing_gen_if vif_p ();
  vga_timing_gen_if vif_s ();

  vga_timing_gen dut (.clk_25(clk), .rst(rst), .vga_o(vif));

  vga_timing_gen #(.HS_POL(1'b1), .VS_POL(1'b1)) dut_p (
    .clk_25(clk), .rst(rst), .vga_o(vif_p)
  );

  vga_timing_gen #(
    .HA(10), .HFP(2), .HSW(3), .HBP(6), .VA(6), .VFP(2), .VSW(2), .VBP(3)
  ) dut_s (
    .clk_25(clk), .rst(rst), .vga_o(vif_s)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Position in the raster is simply elapsed cycles since release modulo frame length.
  function automatic exp_t model(input int ha, hfp, hsw, hbp, va, vfp, vsw, vbp,
                                 input bit hp, vp, input bit in_rst,
                                 input longint kk, input logic [15:0] base);
    exp_t   e;
    int     ht, vt, x, y;
    longint p;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    if (in_rst) begin
      x    = ht - 1;
      y    = vt - 1;
      e.fc = 16'd0;
    end else begin
      p    = kk % longint'(ht * vt);
      x    = int'(p % ht);
      y    = int'(p / ht);
      e.fc = base + 16'(kk / longint'(ht * vt) + 1);
    end
    e.sx  = 10'(x);
    e.sy  = 10'(y);
    e.act = (x < ha) && (y < va);
    e.hs  = (x >= ha + hfp && x < ha + hfp + hsw) ? hp : ~hp;
    e.vs  = (y >= va + vfp && y < va + vfp + vsw) ? vp : ~vp;
    e.ls  = !in_rst && (x == 0);
    e.fs  = !in_rst && (x == 0) && (y == 0);
    return e;
  endfunction

  task automatic check_vec(input string name, input exp_t a, input exp_t e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s k=%0d got sx=%0d sy=%0d act=%b hs=%b vs=%b ls=%b fs=%b fc=%0d, want sx=%0d sy=%0d act=%b hs=%b vs=%b ls=%b fs=%b fc=%0d",
               name, k, a.sx, a.sy, a.act, a.hs, a.vs, a.ls, a.fs, a.fc,
               e.sx, e.sy, e.act, e.hs, e.vs, e.ls, e.fs, e.fc);
    end
  endtask

  task automatic lit(input string name, input longint a, input longint e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", name, a, e);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_rst   = 1'b1;
      m_valid = 1'b1;
    end else if (m_rst) begin
      m_rst = 1'b0;
      k     = 0;
    end else begin
      k++;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check_vec("dut", {vif.sx, vif.sy, vif.active_pixel, vif.hsync, vif.vsync,
                        vif.line_start, vif.frame_start, vif.frame_count},
                model(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, m_rst, k, 16'd0));
      check_vec("dut_p", {vif_p.sx, vif_p.sy, vif_p.active_pixel, vif_p.hsync, vif_p.vsync,
                          vif_p.line_start, vif_p.frame_start, vif_p.frame_count},
                model(640, 16, 96, 48, 480, 10, 2, 33, 1'b1, 1'b1, m_rst, k, 16'd0));
      check_vec("dut_s", {vif_s.sx, vif_s.sy, vif_s.active_pixel, vif_s.hsync, vif_s.vsync,
                          vif_s.line_start, vif_s.frame_start, vif_s.frame_count},
                model(10, 2, 3, 6, 6, 2, 2, 3, 1'b0, 1'b0, m_rst, k, base_s));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at k=%0d", k);
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, act_n, hsl_n, php_n;
    int          last, fs_n, ls_n, vsl_n, actb_n, act_s_n, vb_n;
    logic [15:0] first_fc;
    vectors     = 0;
    miscompares = 0;
    m_valid     = 1'b0;
    m_rst       = 1'b0;
    k           = 0;
    base_s      = 16'd0;
    rst         = 1'b1;

    repeat (3) @(negedge clk);
    lit("rst_sx", vif.sx, 799);
    lit("rst_sy", vif.sy, 524);
    lit("rst_hsync", vif.hsync, 1);
    lit("rst_vsync", vif.vsync, 1);
    lit("rst_active", vif.active_pixel, 0);
    lit("rst_fc", vif.frame_count, 0);
    lit("rst_p_hsync", vif_p.hsync, 0);
    lit("rst_s_sx", vif_s.sx, 20);
    lit("rst_s_sy", vif_s.sy, 12);
    rst = 1'b0;

    @(negedge clk);
    lit("rel_sx", vif.sx, 0);
    lit("rel_sy", vif.sy, 0);
    lit("rel_active", vif.active_pixel, 1);
    lit("rel_fs", vif.frame_start, 1);
    lit("rel_ls", vif.line_start, 1);
    lit("rel_fc", vif.frame_count, 1);

    act_n = 0; hsl_n = 0; php_n = 0;
    for (int i = 0; i < 800; i++) begin
      if (vif.active_pixel) act_n++;
      if (!vif.hsync) hsl_n++;
      if (vif_p.hsync) php_n++;
      if (i == 639) lit("line_act_639", vif.active_pixel, 1);
      if (i == 640) lit("line_act_640", vif.active_pixel, 0);
      if (i == 655) lit("line_hs_655", vif.hsync, 1);
      if (i == 656) lit("line_hs_656", vif.hsync, 0);
      if (i == 751) lit("line_hs_751", vif.hsync, 0);
      if (i == 752) lit("line_hs_752", vif.hsync, 1);
      @(negedge clk);
    end
    lit("line_active_cnt", act_n, 640);
    lit("line_hsync_low_cnt", hsl_n, 96);
    lit("line_p_hsync_high_cnt", php_n, 96);
    lit("wrap_sx", vif.sx, 0);
    lit("wrap_sy", vif.sy, 1);
    lit("wrap_ls", vif.line_start, 1);
    lit("wrap_fs", vif.frame_start, 0);

    n = 0;
    while (!vif_s.frame_start && n < 600) begin
      @(negedge clk);
      n++;
    end
    lit("s_fs_found", vif_s.frame_start, 1);
    first_fc = vif_s.frame_count;
    lit("s_fc_first", first_fc, 4);
    last = 0; fs_n = 0; ls_n = 0; vsl_n = 0; actb_n = 0; act_s_n = 0; vb_n = 0;
    for (int i = 0; i < 3 * 273; i++) begin
      if (vif_s.frame_start) begin
        if (fs_n > 0) begin
          lit("s_fs_period", i - last, 273);
          lit("s_fc_step", vif_s.frame_count, longint'(first_fc) + fs_n);
        end
        last = i;
        fs_n++;
      end
      if (vif_s.line_start) ls_n++;
      if (!vif_s.vsync) vsl_n++;
      if (vif_s.active_pixel && vif_s.sy >= 10'd6) actb_n++;
      if (vif_s.active_pixel) act_s_n++;
      if (vif_s.sy == 10'd12 && vif_s.sx == 10'd0) vb_n++;
      @(negedge clk);
    end
    lit("s_fs_cnt", fs_n, 3);
    lit("s_ls_cnt", ls_n, 39);
    lit("s_vsync_low_cnt", vsl_n, 126);
    lit("s_active_in_vblank", actb_n, 0);
    lit("s_active_cnt", act_s_n, 180);
    lit("s_vblank_strobe_cnt", vb_n, 3);

    n = 0;
    while (vif.sx != 10'd300 && n < 900) begin
      @(negedge clk);
      n++;
    end
    lit("mid_at_300", vif.sx, 300);
    rst = 1'b1;
    @(negedge clk);
    lit("mid_rst_sx", vif.sx, 799);
    lit("mid_rst_sy", vif.sy, 524);
    lit("mid_rst_active", vif.active_pixel, 0);
    lit("mid_rst_ls", vif.line_start, 0);
    lit("mid_rst_fc", vif.frame_count, 0);
    rst = 1'b0;
    @(negedge clk);
    lit("mid_rel_sx", vif.sx, 0);
    lit("mid_rel_sy", vif.sy, 0);
    lit("mid_rel_fs", vif.frame_start, 1);
    lit("mid_rel_fc", vif.frame_count, 1);

    repeat (100) @(negedge clk);
    #2;
    force dut_s.frame_count_q = 16'hFFFF;
    base_s = 16'hFFFE;
    @(negedge clk);
    #2;
    release dut_s.frame_count_q;
    lit("s_forced_fc", vif_s.frame_count, 65535);
    n = 0;
    while (!vif_s.frame_start && n < 400) begin
      @(negedge clk);
      n++;
    end
    lit("s_wrap_fs_found", vif_s.frame_start, 1);
    lit("s_wrap_fc", vif_s.frame_count, 0);
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
